// File: rtl/jux_axi_rd_arbiter.sv
// jux_axi_rd_arbiter
//   Shares one AXI4 master read port between NUM_REQ requesters.
//   - Grants AR requests round-robin and forwards the winner's payload.
//   - Prefixes the forwarded ARID with the requester index.
//   - Routes R beats back by that index, combinationally and without buffering.
//   - Caps the outstanding bursts per requester at OUTSTD_MAX.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_ar*                    packed per-requester AR channels (requester i = slice i)
//   s_rvalid / s_rready      per-requester R handshake
//   s_rid/s_rdata/s_rresp/s_rlast  shared R payload, index tag stripped from s_rid
//   m_ar*                    master AR channel, m_arid = {grant index, requester ARID}
//   m_r*                     master R channel, m_rid carries the index tag
//   err                      sticky: illegal R tag, or an rlast with no burst outstanding
module jux_axi_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDX_W      = 2,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_BITS  = 64,
    parameter int unsigned OUTSTD_MAX = 4
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_REQ-1:0]               s_arvalid,
    output logic [NUM_REQ-1:0]               s_arready,
    input  logic [NUM_REQ*ID_WIDTH-1:0]      s_arid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    s_araddr,
    input  logic [NUM_REQ*8-1:0]             s_arlen,
    input  logic [NUM_REQ*3-1:0]             s_arsize,
    input  logic [NUM_REQ*2-1:0]             s_arburst,
    output logic [NUM_REQ-1:0]               s_rvalid,
    input  logic [NUM_REQ-1:0]               s_rready,
    output logic [ID_WIDTH-1:0]              s_rid,
    output logic [DATA_BITS-1:0]             s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rlast,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    output logic [IDX_W+ID_WIDTH-1:0]        m_arid,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic [7:0]                       m_arlen,
    output logic [2:0]                       m_arsize,
    output logic [1:0]                       m_arburst,
    input  logic                             m_rvalid,
    output logic                             m_rready,
    input  logic [IDX_W+ID_WIDTH-1:0]        m_rid,
    input  logic [DATA_BITS-1:0]             m_rdata,
    input  logic [1:0]                       m_rresp,
    input  logic                             m_rlast,
    output logic                             err
);

    localparam int unsigned TID_W = IDX_W + ID_WIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         gnt_q, gnt_d;
    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0][3:0]  cnt_q, cnt_d;
    logic                     err_q, err_d;

    logic [NUM_REQ-1:0]       eligible;
    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [IDX_W:0]           pick_pos;
    logic                     ar_hs;

    logic [IDX_W-1:0]         r_tag;
    logic [NUM_REQ-1:0]       r_sel;
    logic                     r_legal;
    logic                     rlast_hs;

    // Eligibility uses the registered count, so a slot freed by an rlast
    // becomes usable on the following IDLE evaluation.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = s_arvalid[i] && (cnt_q[i] < 4'(OUTSTD_MAX));
        end
    end

    // Round-robin search starting just after rr_ptr. Each candidate position is
    // formed with one-extra-bit arithmetic and a single wrap, then matched
    // against constant indices so no variable bit-select is needed.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_pos   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pick_pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (pick_pos >= (IDX_W+1)'(NUM_REQ)) begin
                pick_pos = pick_pos - (IDX_W+1)'(NUM_REQ);
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!pick_valid && pick_pos == (IDX_W+1)'(i) && eligible[i]) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign ar_hs = (state_q == ST_GRANT) && m_arready;

    // AR FSM next state
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The grant is held until the handshake, even if the requester
                // withdraws its arvalid.
                if (m_arready) begin
                    rr_ptr_d = gnt_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AR outputs: payload is a plain mux of the granted slice
    always_comb begin
        m_arvalid = (state_q == ST_GRANT);
        s_arready = '0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == IDX_W'(i)) begin
                s_arready[i] = (state_q == ST_GRANT) && m_arready;
                m_arid       = {gnt_q, s_arid[i*ID_WIDTH +: ID_WIDTH]};
                m_araddr     = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_arlen      = s_arlen[i*8 +: 8];
                m_arsize     = s_arsize[i*3 +: 3];
                m_arburst    = s_arburst[i*2 +: 2];
            end
        end
    end

    // R path: route by the tag; an out-of-range tag matches no requester and
    // is sunk with m_rready held high.
    assign r_tag = m_rid[TID_W-1:ID_WIDTH];

    always_comb begin
        r_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            r_sel[i] = (r_tag == IDX_W'(i));
        end
    end

    assign r_legal  = |r_sel;
    assign s_rvalid = m_rvalid ? r_sel : '0;
    assign m_rready = m_rvalid && (r_legal ? |(s_rready & r_sel) : 1'b1);
    assign rlast_hs = m_rvalid && m_rready && m_rlast;
    assign s_rid    = m_rid[ID_WIDTH-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;

    // Outstanding counters and sticky error
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (m_rvalid && !r_legal) begin
            err_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ar_hs && gnt_q == IDX_W'(i) && !(rlast_hs && r_sel[i])) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (rlast_hs && r_sel[i] && !(ar_hs && gnt_q == IDX_W'(i))) begin
                if (cnt_q[i] == 4'd0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 4'd1;
                end
            end
        end
    end

    assign err = err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= IDX_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_jux_axi_rd_arbiter.sv
module tb_jux_axi_rd_arbiter;

    int checks = 0;
    int errors = 0;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    // main instance, NUM_REQ = 4
    logic [3:0]   s_arvalid, s_arready, s_rvalid, s_rready;
    logic [15:0]  s_arid;
    logic [127:0] s_araddr;
    logic [31:0]  s_arlen;
    logic [11:0]  s_arsize;
    logic [7:0]   s_arburst;
    logic [3:0]   s_rid;
    logic [63:0]  s_rdata, m_rdata;
    logic [1:0]   s_rresp, m_rresp, m_arburst;
    logic         s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err;
    logic [5:0]   m_arid, m_rid;
    logic [31:0]  m_araddr;
    logic [7:0]   m_arlen;
    logic [2:0]   m_arsize;

    // error instance, NUM_REQ = 3 (tag 3 is illegal)
    logic [2:0]   s3_arvalid, s3_arready, s3_rvalid, s3_rready;
    logic [11:0]  s3_arid;
    logic [95:0]  s3_araddr;
    logic [23:0]  s3_arlen;
    logic [8:0]   s3_arsize;
    logic [5:0]   s3_arburst;
    logic [3:0]   s3_rid;
    logic [63:0]  s3_rdata, m3_rdata;
    logic [1:0]   s3_rresp, m3_rresp, m3_arburst;
    logic         s3_rlast, m3_arvalid, m3_arready, m3_rvalid, m3_rready, m3_rlast, err3;
    logic [5:0]   m3_arid, m3_rid;
    logic [31:0]  m3_araddr;
    logic [7:0]   m3_arlen;
    logic [2:0]   m3_arsize;

    jux_axi_rd_arbiter #(.NUM_REQ(4), .IDX_W(2), .ID_WIDTH(4), .ADDR_WIDTH(32),
                         .DATA_BITS(64), .OUTSTD_MAX(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .err(err)
    );

    jux_axi_rd_arbiter #(.NUM_REQ(3), .IDX_W(2), .ID_WIDTH(4), .ADDR_WIDTH(32),
                         .DATA_BITS(64), .OUTSTD_MAX(4)) dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .s_arvalid(s3_arvalid), .s_arready(s3_arready), .s_arid(s3_arid), .s_araddr(s3_araddr),
        .s_arlen(s3_arlen), .s_arsize(s3_arsize), .s_arburst(s3_arburst),
        .s_rvalid(s3_rvalid), .s_rready(s3_rready), .s_rid(s3_rid), .s_rdata(s3_rdata),
        .s_rresp(s3_rresp), .s_rlast(s3_rlast),
        .m_arvalid(m3_arvalid), .m_arready(m3_arready), .m_arid(m3_arid), .m_araddr(m3_araddr),
        .m_arlen(m3_arlen), .m_arsize(m3_arsize), .m_arburst(m3_arburst),
        .m_rvalid(m3_rvalid), .m_rready(m3_rready), .m_rid(m3_rid), .m_rdata(m3_rdata),
        .m_rresp(m3_rresp), .m_rlast(m3_rlast), .err(err3)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_inputs();
        s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0;
        m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
        s3_arvalid = '0; s3_arid = '0; s3_araddr = '0; s3_arlen = '0; s3_arsize = '0;
        s3_arburst = '0; s3_rready = '0; m3_arready = 1'b0; m3_rvalid = 1'b0; m3_rid = '0;
        m3_rdata = '0; m3_rresp = '0; m3_rlast = 1'b0;
    endtask

    // Leaves time at one cycle after the release edge; the next edge is the
    // first one at which the FSM can grant.
    task automatic do_reset();
        clear_inputs();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic set_ar(input int r, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len);
        s_arid[r*4 +: 4]    = id;
        s_araddr[r*32 +: 32] = addr;
        s_arlen[r*8 +: 8]    = len;
        s_arsize[r*3 +: 3]   = 3'd3;
        s_arburst[r*2 +: 2]  = 2'd1;
    endtask

    task automatic test_reset();
        clear_inputs();
        aresetn = 1'b0;
        tick();
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b expected 0", m_arvalid); end
        checks++; if (s_arready !== 4'b0) begin errors++; $display("FAIL reset_s_arready: got %b expected 0000", s_arready); end
        checks++; if (s_rvalid !== 4'b0) begin errors++; $display("FAIL reset_s_rvalid: got %b expected 0000", s_rvalid); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL reset_m_rready: got %b expected 0", m_rready); end
        checks++; if (err !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b/%b expected 0/0", err, err3); end
        aresetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_ar(2, 4'h5, 32'h1000, 8'd3);
        s_arvalid = 4'b0100;
        m_arready = 1'b1;
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_arid !== 6'h25) begin errors++; $display("FAIL single_arid: got v=%b id=%h expected v=1 id=25", m_arvalid, m_arid); end
        checks++; if (m_araddr !== 32'h1000 || m_arlen !== 8'd3) begin errors++; $display("FAIL single_payload: got %h/%h expected 1000/03", m_araddr, m_arlen); end
        checks++; if (s_arready !== 4'b0100) begin errors++; $display("FAIL single_s_arready: got %b expected 0100", s_arready); end
        tick();
        s_arvalid = 4'b0000;
        #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL single_idle_after_hs: got %b expected 0", m_arvalid); end
        checks++; if (dut.cnt_q[2] !== 4'd1) begin errors++; $display("FAIL single_cnt_inc: got %0d expected 1", dut.cnt_q[2]); end
        s_rready = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rid    = 6'h25;
            m_rdata  = 64'hDEAD_0000 + 64'(b);
            m_rlast  = (b == 3);
            #1;
            checks++; if (s_rvalid !== 4'b0100 || m_rready !== 1'b1) begin errors++; $display("FAIL single_r_route beat %0d: got rvalid=%b rready=%b expected 0100/1", b, s_rvalid, m_rready); end
            checks++; if (s_rid !== 4'h5 || s_rdata !== 64'hDEAD_0000 + 64'(b) || s_rlast !== (b == 3)) begin errors++; $display("FAIL single_r_payload beat %0d: got id=%h data=%h last=%b", b, s_rid, s_rdata, s_rlast); end
            tick();
        end
        m_rvalid = 1'b0; m_rlast = 1'b0;
        checks++; if (dut.cnt_q[2] !== 4'd0) begin errors++; $display("FAIL single_cnt_dec: got %0d expected 0", dut.cnt_q[2]); end
    endtask

    task automatic test_round_robin();
        int tags[$];
        int cyc[$];
        do_reset();
        for (int r = 0; r < 4; r++) set_ar(r, 4'(r + 8), 32'h100 * (r + 1), 8'd0);
        s_arvalid = 4'b1111;
        m_arready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (m_arvalid) begin
                tags.push_back(int'(m_arid[5:4]));
                cyc.push_back(i);
                checks++; if (s_arready !== (4'b0001 << m_arid[5:4])) begin errors++; $display("FAIL rr_s_arready cycle %0d: got %b for tag %0d", i, s_arready, m_arid[5:4]); end
            end
        end
        s_arvalid = 4'b0000;
        checks++; if (tags.size() !== 6) begin errors++; $display("FAIL rr_grant_count: got %0d expected 6", tags.size()); end
        for (int k = 0; k < tags.size() && k < 6; k++) begin
            checks++; if (tags[k] !== (k % 4)) begin errors++; $display("FAIL rr_order grant %0d: got %0d expected %0d", k, tags[k], k % 4); end
            if (k > 0) begin
                checks++; if (cyc[k] - cyc[k-1] !== 2) begin errors++; $display("FAIL rr_spacing grant %0d: got %0d expected 2", k, cyc[k] - cyc[k-1]); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ar(1, 4'hA, 32'h2222_0000, 8'd7);
        s_arvalid = 4'b0010;
        m_arready = 1'b0;
        tick();
        set_ar(0, 4'h3, 32'h3333_0000, 8'd1);
        s_arvalid = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            if (c == 15) s_arvalid = 4'b0001;  // grant must not be revoked
            #1;
            checks++; if (m_arvalid !== 1'b1 || m_arid !== 6'h1A || m_araddr !== 32'h2222_0000 || m_arlen !== 8'd7) begin errors++; $display("FAIL bp_hold cycle %0d: got v=%b id=%h addr=%h len=%h", c, m_arvalid, m_arid, m_araddr, m_arlen); end
            checks++; if (s_arready !== 4'b0000) begin errors++; $display("FAIL bp_s_arready cycle %0d: got %b expected 0000", c, s_arready); end
            tick();
        end
        m_arready = 1'b1;
        #1;
        checks++; if (s_arready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b expected 0010", s_arready); end
        tick();
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_arid[5:4] !== 2'd0) begin errors++; $display("FAIL bp_next_grant: got v=%b tag=%0d expected 1/0", m_arvalid, m_arid[5:4]); end
        s_arvalid = 4'b0000;
    endtask

    task automatic test_outstanding_limit();
        int ngr;
        ngr = 0;
        do_reset();
        set_ar(0, 4'h1, 32'h4000, 8'd0);
        set_ar(1, 4'h2, 32'h5000, 8'd0);
        s_arvalid = 4'b0001;
        m_arready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (m_arvalid) begin
                ngr++;
                checks++; if (m_arid[5:4] !== 2'd0) begin errors++; $display("FAIL lim_grant_tag cycle %0d: got %0d expected 0", i, m_arid[5:4]); end
            end
        end
        checks++; if (ngr !== 4) begin errors++; $display("FAIL lim_grant_count: got %0d expected 4", ngr); end
        s_arvalid = 4'b0011;
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_arid[5:4] !== 2'd1) begin errors++; $display("FAIL lim_other_granted: got v=%b tag=%0d expected 1/1", m_arvalid, m_arid[5:4]); end
        tick();
        s_arvalid = 4'b0001;
        tick();
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL lim_blocked: got %b expected 0", m_arvalid); end
        m_rvalid = 1'b1; m_rid = 6'h01; m_rlast = 1'b1; s_rready = 4'b0001;
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL lim_still_blocked_same_cycle: got %b expected 0", m_arvalid); end
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_arid[5:4] !== 2'd0) begin errors++; $display("FAIL lim_fifth_granted: got v=%b tag=%0d expected 1/0", m_arvalid, m_arid[5:4]); end
        s_arvalid = 4'b0000;
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_ar(3, 4'h7, 32'h6000, 8'd0);
        s_arvalid = 4'b1000;
        m_arready = 1'b1;
        repeat (4) tick();
        checks++; if (dut.cnt_q[3] !== 4'd2) begin errors++; $display("FAIL sim_cnt_pre: got %0d expected 2", dut.cnt_q[3]); end
        tick();
        checks++; if (m_arvalid !== 1'b1 || m_arid !== 6'h37) begin errors++; $display("FAIL sim_grant: got v=%b id=%h expected 1/37", m_arvalid, m_arid); end
        m_rvalid = 1'b1; m_rid = 6'h37; m_rlast = 1'b1; s_rready = 4'b1000;
        #1;
        checks++; if (m_rready !== 1'b1 || s_rvalid !== 4'b1000) begin errors++; $display("FAIL sim_r_route: got rready=%b rvalid=%b expected 1/1000", m_rready, s_rvalid); end
        tick();
        m_rvalid = 1'b0; m_rlast = 1'b0; s_arvalid = 4'b0000;
        checks++; if (dut.cnt_q[3] !== 4'd2) begin errors++; $display("FAIL sim_cnt_post: got %0d expected 2", dut.cnt_q[3]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sim_err: got %b expected 0", err); end
    endtask

    task automatic test_async_reset();
        do_reset();
        set_ar(0, 4'h4, 32'h7000, 8'd0);
        s_arvalid = 4'b0001;
        m_arready = 1'b0;
        tick();
        m_arready = 1'b1;
        #1;
        checks++; if (m_arvalid !== 1'b1 || s_arready !== 4'b0001) begin errors++; $display("FAIL arst_pre: got v=%b rdy=%b expected 1/0001", m_arvalid, s_arready); end
        #1;
        aresetn = 1'b0;
        #1;
        checks++; if (m_arvalid !== 1'b0 || s_arready !== 4'b0000) begin errors++; $display("FAIL arst_drop: got v=%b rdy=%b expected 0/0000", m_arvalid, s_arready); end
        do_reset();
    endtask

    task automatic test_err_bad_tag();
        do_reset();
        m3_rvalid = 1'b1; m3_rid = 6'h32; s3_rready = 3'b000;
        #1;
        checks++; if (m3_rready !== 1'b1) begin errors++; $display("FAIL bad_tag_sink: got %b expected 1", m3_rready); end
        checks++; if (s3_rvalid !== 3'b000) begin errors++; $display("FAIL bad_tag_rvalid: got %b expected 000", s3_rvalid); end
        tick();
        m3_rvalid = 1'b0;
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL bad_tag_err: got %b expected 1", err3); end
        repeat (3) tick();
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL bad_tag_sticky: got %b expected 1", err3); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_tag_other_inst: got %b expected 0", err); end
        do_reset();
        checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL bad_tag_reset_clears: got %b expected 0", err3); end
    endtask

    task automatic test_err_extra_rlast();
        do_reset();
        m3_rvalid = 1'b1; m3_rid = 6'h10; m3_rlast = 1'b1; s3_rready = 3'b010;
        #1;
        checks++; if (s3_rvalid !== 3'b010 || m3_rready !== 1'b1) begin errors++; $display("FAIL extra_rlast_route: got rvalid=%b rready=%b expected 010/1", s3_rvalid, m3_rready); end
        tick();
        m3_rvalid = 1'b0; m3_rlast = 1'b0;
        checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL extra_rlast_err: got %b expected 1", err3); end
        checks++; if (dut3.cnt_q[1] !== 4'd0) begin errors++; $display("FAIL extra_rlast_cnt: got %0d expected 0", dut3.cnt_q[1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_outstanding_limit();
        test_simultaneous();
        test_async_reset();
        test_err_bad_tag();
        test_err_extra_rlast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
